game_phase_ctrl: RTL and testbench

- Parametrised successor to the symbol-counting game's level/period control.
- Merges level sequencing, phase timing, game/user symbol counting, scoring and one-cycle event blips into a single synchronous block on Clk100M.
- Level count, phase durations, counter widths and pass tolerance are all parameters.
- Per-level game-phase length, saturating counters, win/loss terminal states and explicit start/restart are new behaviour compared with the fixed-level controller.

---
 rtl/game_phase_ctrl_if.sv | 37 +++
 rtl/game_phase_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_game_phase_ctrl.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/game_phase_ctrl_if.sv
// Handshake bundle for game_phase_ctrl: game inputs from the outside world
// and the registered phase/level/count status returned by the controller.
interface game_phase_ctrl_if #(
    parameter int LEVEL_W = 3,
    parameter int CNT_W   = 7,
    parameter int CD_W    = 4
);
    logic               i_tick_1hz;
    logic               i_start;
    logic               i_sym_valid;
    logic               i_sym_special;
    logic               i_up;
    logic               i_down;

    logic [2:0]         o_phase;
    logic               o_phase_start;
    logic [LEVEL_W-1:0] o_level;
    logic               o_level_chng;
    logic [CD_W-1:0]    o_count_down;
    logic [CNT_W-1:0]   o_user_count;
    logic [CNT_W-1:0]   o_game_count;
    logic [CNT_W-1:0]   o_diff;
    logic               o_loss;
    logic               o_win;

    modport master (
        output i_tick_1hz, i_start, i_sym_valid, i_sym_special, i_up, i_down,
        input  o_phase, o_phase_start, o_level, o_level_chng, o_count_down,
        input  o_user_count, o_game_count, o_diff, o_loss, o_win
    );

    modport slave (
        input  i_tick_1hz, i_start, i_sym_valid, i_sym_special, i_up, i_down,
        output o_phase, o_phase_start, o_level, o_level_chng, o_count_down,
        output o_user_count, o_game_count, o_diff, o_loss, o_win
    );
endinterface

// File: rtl/game_phase_ctrl.sv
// Level/phase sequencer for the symbol-counting game: times each phase in
// 1 Hz ticks, counts game and user symbols, scores each level, flags win/loss.
module game_phase_ctrl #(
    parameter int NUM_LEVELS     = 8,
    parameter int LEVEL_W        = 3,
    parameter int CNT_W          = 7,
    parameter int CD_W           = 4,
    parameter int PRELIM_SECS    = 3,
    parameter int GAME_SECS_BASE = 10,
    parameter int GAME_SECS_STEP = 0,
    parameter int ANSWER_SECS    = 5,
    parameter int POST_SECS      = 2,
    parameter int TOL            = 0
) (
    input  logic             Clk100M,
    input  logic             reset,
    game_phase_ctrl_if.slave bus
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_PRELIM = 3'd1;
    localparam logic [2:0] S_GAME   = 3'd2;
    localparam logic [2:0] S_ANSWER = 3'd3;
    localparam logic [2:0] S_POST   = 3'd4;
    localparam logic [2:0] S_LOST   = 3'd5;
    localparam logic [2:0] S_WON    = 3'd6;

    localparam logic [CD_W-1:0]    CD_PRELIM  = CD_W'(PRELIM_SECS);
    localparam logic [CD_W-1:0]    CD_ANSWER  = CD_W'(ANSWER_SECS);
    localparam logic [CD_W-1:0]    CD_POST    = CD_W'(POST_SECS);
    localparam logic [CD_W-1:0]    CD_MAX     = '1;
    localparam logic [CNT_W-1:0]   CNT_MAX    = '1;
    localparam logic [CNT_W-1:0]   TOL_C      = CNT_W'(TOL);
    localparam logic [LEVEL_W-1:0] LAST_LEVEL = LEVEL_W'(NUM_LEVELS - 1);

    logic [2:0]         r_phase;
    logic [2:0]         r_phase_d;
    logic               r_phase_start;
    logic [LEVEL_W-1:0] r_level;
    logic               r_lvl_inc;
    logic               r_level_chng;
    logic [CD_W-1:0]    r_cd;
    logic [CNT_W-1:0]   r_user;
    logic [CNT_W-1:0]   r_game;
    logic [CNT_W-1:0]   r_diff;
    logic               r_loss;
    logic               r_win;

    logic [2:0]         w_next_phase;
    logic [CD_W-1:0]    w_next_cd;
    logic [LEVEL_W-1:0] w_next_level;
    logic [CNT_W-1:0]   w_next_user;
    logic [CNT_W-1:0]   w_next_game;
    logic [CNT_W-1:0]   w_next_diff;
    logic               w_clear;
    logic               w_latch_diff;
    logic               w_lvl_inc;
    logic               w_timed;
    logic [31:0]        w_game_len;
    logic [CD_W-1:0]    w_game_cd;
    logic [CNT_W-1:0]   w_abs_diff;

    // GAME length grows per level but must fit the countdown register
    assign w_game_len = 32'(GAME_SECS_BASE) + 32'(r_level) * 32'(GAME_SECS_STEP);
    assign w_game_cd  = (w_game_len > 32'(CD_MAX)) ? CD_MAX : w_game_len[CD_W-1:0];
    assign w_abs_diff = (r_user >= r_game) ? (r_user - r_game) : (r_game - r_user);

    assign w_timed = (r_phase == S_PRELIM) || (r_phase == S_GAME) ||
                     (r_phase == S_ANSWER) || (r_phase == S_POST);

    always_comb begin
        w_next_phase = r_phase;
        w_next_cd    = r_cd;
        w_next_level = r_level;
        w_clear      = 1'b0;
        w_latch_diff = 1'b0;
        w_lvl_inc    = 1'b0;

        if (!w_timed) begin
            if (bus.i_start) begin
                w_next_phase = S_PRELIM;
                w_next_cd    = CD_PRELIM;
                w_next_level = '0;
                w_clear      = 1'b1;
            end
        end else if (bus.i_tick_1hz) begin
            if (r_cd > 1) begin
                w_next_cd = r_cd - 1'b1;
            end else begin
                case (r_phase)
                    S_PRELIM: begin
                        w_next_phase = S_GAME;
                        w_next_cd    = w_game_cd;
                    end
                    S_GAME: begin
                        w_next_phase = S_ANSWER;
                        w_next_cd    = CD_ANSWER;
                    end
                    // Score on the counts as they stood before this edge
                    S_ANSWER: begin
                        w_latch_diff = 1'b1;
                        if (w_abs_diff <= TOL_C) begin
                            w_next_phase = S_POST;
                            w_next_cd    = CD_POST;
                        end else begin
                            w_next_phase = S_LOST;
                            w_next_cd    = '0;
                        end
                    end
                    S_POST: begin
                        if (r_level == LAST_LEVEL) begin
                            w_next_phase = S_WON;
                            w_next_cd    = '0;
                        end else begin
                            w_next_phase = S_PRELIM;
                            w_next_cd    = CD_PRELIM;
                            w_next_level = r_level + 1'b1;
                            w_clear      = 1'b1;
                            w_lvl_inc    = 1'b1;
                        end
                    end
                    default: begin
                        w_next_phase = S_IDLE;
                        w_next_cd    = '0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        w_next_game = r_game;
        w_next_user = r_user;
        w_next_diff = r_diff;

        if (w_clear) begin
            w_next_game = '0;
        end else if ((r_phase == S_GAME) && bus.i_sym_valid && bus.i_sym_special &&
                     (r_game != CNT_MAX)) begin
            w_next_game = r_game + 1'b1;
        end

        // Simultaneous up and down cancel out
        if (w_clear) begin
            w_next_user = '0;
        end else if ((r_phase == S_GAME) || (r_phase == S_ANSWER)) begin
            if (bus.i_up && !bus.i_down && (r_user != CNT_MAX)) begin
                w_next_user = r_user + 1'b1;
            end else if (bus.i_down && !bus.i_up && (r_user != '0)) begin
                w_next_user = r_user - 1'b1;
            end
        end

        if (w_clear) begin
            w_next_diff = '0;
        end else if (w_latch_diff) begin
            w_next_diff = w_abs_diff;
        end
    end

    // Event pulses trail the state change by one cycle via the delayed copies
    always_ff @(posedge Clk100M) begin
        if (reset) begin
            r_phase       <= S_IDLE;
            r_phase_d     <= S_IDLE;
            r_phase_start <= 1'b0;
            r_level       <= '0;
            r_lvl_inc     <= 1'b0;
            r_level_chng  <= 1'b0;
            r_cd          <= '0;
            r_user        <= '0;
            r_game        <= '0;
            r_diff        <= '0;
            r_loss        <= 1'b0;
            r_win         <= 1'b0;
        end else begin
            r_phase       <= w_next_phase;
            r_phase_d     <= r_phase;
            r_phase_start <= (r_phase != r_phase_d);
            r_level       <= w_next_level;
            r_lvl_inc     <= w_lvl_inc;
            r_level_chng  <= r_lvl_inc;
            r_cd          <= w_next_cd;
            r_user        <= w_next_user;
            r_game        <= w_next_game;
            r_diff        <= w_next_diff;
            r_loss        <= (w_next_phase == S_LOST);
            r_win         <= (w_next_phase == S_WON);
        end
    end

    assign bus.o_phase       = r_phase;
    assign bus.o_phase_start = r_phase_start;
    assign bus.o_level       = r_level;
    assign bus.o_level_chng  = r_level_chng;
    assign bus.o_count_down  = r_cd;
    assign bus.o_user_count  = r_user;
    assign bus.o_game_count  = r_game;
    assign bus.o_diff        = r_diff;
    assign bus.o_loss        = r_loss;
    assign bus.o_win         = r_win;

endmodule

// File: tb/tb_game_phase_ctrl.sv
// Directed bench for game_phase_ctrl: three parameter sets share one stimulus
// stream; each scenario checks only the instance it targets.
module tb_game_phase_ctrl;

    logic clk = 1'b0;
    logic rst, start, tick, symV, symS, up, down;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    game_phase_ctrl_if #(.LEVEL_W(3), .CNT_W(7), .CD_W(4)) ifA ();
    game_phase_ctrl_if #(.LEVEL_W(3), .CNT_W(3), .CD_W(4)) ifB ();
    game_phase_ctrl_if #(.LEVEL_W(3), .CNT_W(7), .CD_W(4)) ifC ();

    game_phase_ctrl dutA (.Clk100M(clk), .reset(rst), .bus(ifA));

    game_phase_ctrl #(.NUM_LEVELS(8), .CNT_W(3), .GAME_SECS_STEP(2), .TOL(1))
        dutB (.Clk100M(clk), .reset(rst), .bus(ifB));

    game_phase_ctrl #(.NUM_LEVELS(2)) dutC (.Clk100M(clk), .reset(rst), .bus(ifC));

    assign ifA.i_tick_1hz = tick;  assign ifB.i_tick_1hz = tick;  assign ifC.i_tick_1hz = tick;
    assign ifA.i_start    = start; assign ifB.i_start    = start; assign ifC.i_start    = start;
    assign ifA.i_sym_valid = symV; assign ifB.i_sym_valid = symV; assign ifC.i_sym_valid = symV;
    assign ifA.i_sym_special = symS; assign ifB.i_sym_special = symS; assign ifC.i_sym_special = symS;
    assign ifA.i_up   = up;   assign ifB.i_up   = up;   assign ifC.i_up   = up;
    assign ifA.i_down = down; assign ifB.i_down = down; assign ifC.i_down = down;

    typedef struct {
        logic start, tick, symV, symS, up, down;
        int   phase, cd, user, game, diff, level, ps, lc;
    } vec_t;

    vec_t vecs[$];
    int   pPrev = 0, pLast = 0, lPrev = 0, lLast = 0;

    // Pulse expectations follow from the expected phase/level one vector back
    function automatic void addVec(input logic s, t, sv, ss, u, d,
                                   input int ph, cd, us, gm, df, lv);
        vec_t v;
        v.start = s; v.tick = t; v.symV = sv; v.symS = ss; v.up = u; v.down = d;
        v.phase = ph; v.cd = cd; v.user = us; v.game = gm; v.diff = df; v.level = lv;
        v.ps = (pLast != pPrev) ? 1 : 0;
        v.lc = (lLast == lPrev + 1) ? 1 : 0;
        pPrev = pLast; pLast = ph;
        lPrev = lLast; lLast = lv;
        vecs.push_back(v);
    endfunction

    task automatic applyStimulus(input logic s, t, sv, ss, u, d);
        start = s; tick = t; symV = sv; symS = ss; up = u; down = d;
        @(posedge clk);
        #1;
        start = 0; tick = 0; symV = 0; symS = 0; up = 0; down = 0;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic tickN(input int n);
        repeat (n) applyStimulus(0, 1, 0, 0, 0, 0);
    endtask

    task automatic stepIdle(input int n);
        repeat (n) applyStimulus(0, 0, 0, 0, 0, 0);
    endtask

    task automatic doReset();
        rst = 1;
        repeat (2) begin @(posedge clk); #1; end
        rst = 0;
    endtask

    initial begin
        int gl;
        rst = 1; start = 0; tick = 0; symV = 0; symS = 0; up = 0; down = 0;

        // Defaults: PRELIM 3, GAME 10, ANSWER 5, POST 2, TOL 0
        addVec(0,1,0,0,0,0, 0,0,0,0,0,0);
        addVec(1,0,0,0,0,0, 1,3,0,0,0,0);
        addVec(1,0,0,0,0,0, 1,3,0,0,0,0);
        addVec(0,1,0,0,0,0, 1,2,0,0,0,0);
        addVec(0,1,0,0,0,0, 1,1,0,0,0,0);
        addVec(0,1,0,0,0,0, 2,10,0,0,0,0);
        addVec(0,0,1,1,0,0, 2,10,0,1,0,0);
        addVec(0,0,1,0,0,0, 2,10,0,1,0,0);
        addVec(0,0,1,1,0,0, 2,10,0,2,0,0);
        addVec(0,1,1,1,0,0, 2,9,0,3,0,0);
        addVec(0,0,1,0,0,0, 2,9,0,3,0,0);
        addVec(0,0,1,0,0,0, 2,9,0,3,0,0);
        addVec(0,0,1,1,0,0, 2,9,0,4,0,0);
        for (int i = 1; i <= 4; i++) addVec(0,0,0,0,1,0, 2,9,i,4,0,0);
        for (int c = 8; c >= 1; c--) addVec(0,1,0,0,0,0, 2,c,4,4,0,0);
        addVec(0,1,0,0,0,0, 3,5,4,4,0,0);
        for (int c = 4; c >= 1; c--) addVec(0,1,0,0,0,0, 3,c,4,4,0,0);
        addVec(0,1,0,0,0,0, 4,2,4,4,0,0);
        addVec(0,0,0,0,1,0, 4,2,4,4,0,0);
        addVec(0,1,0,0,0,0, 4,1,4,4,0,0);
        addVec(0,1,0,0,0,0, 1,3,0,0,0,1);
        addVec(0,0,0,0,0,0, 1,3,0,0,0,1);
        addVec(0,0,0,0,0,0, 1,3,0,0,0,1);
        // Level 1: five symbols counted as three -> LOST with diff 2
        addVec(0,1,0,0,0,0, 1,2,0,0,0,1);
        addVec(0,1,0,0,0,0, 1,1,0,0,0,1);
        addVec(0,1,0,0,0,0, 2,10,0,0,0,1);
        for (int i = 1; i <= 5; i++) addVec(0,0,1,1,0,0, 2,10,0,i,0,1);
        for (int i = 1; i <= 3; i++) addVec(0,0,0,0,1,0, 2,10,i,5,0,1);
        for (int c = 9; c >= 1; c--) addVec(0,1,0,0,0,0, 2,c,3,5,0,1);
        addVec(0,1,0,0,0,0, 3,5,3,5,0,1);
        for (int c = 4; c >= 1; c--) addVec(0,1,0,0,0,0, 3,c,3,5,0,1);
        addVec(0,1,0,0,0,0, 5,0,3,5,2,1);
        for (int i = 0; i < 3; i++) addVec(0,1,0,0,0,0, 5,0,3,5,2,1);
        addVec(0,0,0,0,1,0, 5,0,3,5,2,1);
        addVec(1,0,0,0,0,0, 1,3,0,0,0,0);
        addVec(0,0,0,0,0,0, 1,3,0,0,0,0);

        doReset();
        checkOutput("resetA.phase", ifA.o_phase, 0);
        checkOutput("resetA.cd", ifA.o_count_down, 0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].start, vecs[i].tick, vecs[i].symV, vecs[i].symS,
                          vecs[i].up, vecs[i].down);
            checkOutput($sformatf("v%0d.phase", i), ifA.o_phase, vecs[i].phase);
            checkOutput($sformatf("v%0d.count_down", i), ifA.o_count_down, vecs[i].cd);
            checkOutput($sformatf("v%0d.user_count", i), ifA.o_user_count, vecs[i].user);
            checkOutput($sformatf("v%0d.game_count", i), ifA.o_game_count, vecs[i].game);
            checkOutput($sformatf("v%0d.diff", i), ifA.o_diff, vecs[i].diff);
            checkOutput($sformatf("v%0d.level", i), ifA.o_level, vecs[i].level);
            checkOutput($sformatf("v%0d.phase_start", i), ifA.o_phase_start, vecs[i].ps);
            checkOutput($sformatf("v%0d.level_chng", i), ifA.o_level_chng, vecs[i].lc);
            checkOutput($sformatf("v%0d.loss", i), ifA.o_loss, (vecs[i].phase == 5) ? 1 : 0);
            checkOutput($sformatf("v%0d.win", i), ifA.o_win, (vecs[i].phase == 6) ? 1 : 0);
        end

        // Reset asserted mid-GAME at level 2
        doReset();
        applyStimulus(1, 0, 0, 0, 0, 0);
        tickN(40);
        applyStimulus(0, 0, 1, 1, 1, 0);
        tickN(3);
        checkOutput("midGame.phase", ifA.o_phase, 2);
        checkOutput("midGame.level", ifA.o_level, 2);
        rst = 1;
        @(posedge clk); #1;
        checkOutput("rst.phase", ifA.o_phase, 0);
        checkOutput("rst.level", ifA.o_level, 0);
        checkOutput("rst.cd", ifA.o_count_down, 0);
        checkOutput("rst.user", ifA.o_user_count, 0);
        checkOutput("rst.game", ifA.o_game_count, 0);
        checkOutput("rst.phase_start", ifA.o_phase_start, 0);
        checkOutput("rst.level_chng", ifA.o_level_chng, 0);
        @(posedge clk); #1;
        rst = 0;
        stepIdle(1);
        checkOutput("rst.after_ps", ifA.o_phase_start, 0);

        // Instance B: TOL 1, GAME grows by 2 per level, 3-bit counters
        doReset();
        applyStimulus(1, 0, 0, 0, 0, 0);
        for (int L = 0; L < 8; L++) begin
            gl = (10 + 2 * L > 15) ? 15 : 10 + 2 * L;
            if (L == 3) begin
                applyStimulus(0, 0, 0, 0, 1, 0);
                checkOutput("B.prelimUp", ifB.o_user_count, 0);
            end
            tickN(3);
            checkOutput($sformatf("B.L%0d.phase", L), ifB.o_phase, 2);
            checkOutput($sformatf("B.L%0d.gameCd", L), ifB.o_count_down, gl);
            checkOutput($sformatf("B.L%0d.level", L), ifB.o_level, L);
            if (L == 0) begin
                repeat (2) applyStimulus(0, 0, 1, 1, 0, 0);
                repeat (3) applyStimulus(0, 0, 0, 0, 1, 0);
                checkOutput("B.tolUser", ifB.o_user_count, 3);
                checkOutput("B.tolGame", ifB.o_game_count, 2);
            end else if (L == 1) begin
                repeat (9) applyStimulus(0, 0, 0, 0, 1, 0);
                checkOutput("B.userSatHi", ifB.o_user_count, 7);
                repeat (8) applyStimulus(0, 0, 0, 0, 0, 1);
                checkOutput("B.userSatLo", ifB.o_user_count, 0);
                applyStimulus(0, 0, 0, 0, 1, 0);
                applyStimulus(0, 0, 0, 0, 1, 1);
                checkOutput("B.upDownBoth", ifB.o_user_count, 1);
                applyStimulus(0, 0, 0, 0, 0, 1);
            end else if (L == 2) begin
                repeat (9) applyStimulus(0, 0, 1, 1, 0, 0);
                checkOutput("B.gameSat", ifB.o_game_count, 7);
                repeat (9) applyStimulus(0, 0, 0, 0, 1, 0);
                checkOutput("B.userMatch", ifB.o_user_count, 7);
            end
            tickN(gl);
            checkOutput($sformatf("B.L%0d.answer", L), ifB.o_phase, 3);
            tickN(5);
            checkOutput($sformatf("B.L%0d.post", L), ifB.o_phase, 4);
            if (L == 0) checkOutput("B.tolDiff", ifB.o_diff, 1);
            if (L == 3) begin
                applyStimulus(0, 0, 0, 0, 1, 0);
                checkOutput("B.postUp", ifB.o_user_count, 0);
            end
            tickN(2);
            if (L < 7) checkOutput($sformatf("B.L%0d.next", L), ifB.o_level, L + 1);
        end
        checkOutput("B.wonPhase", ifB.o_phase, 6);
        checkOutput("B.win", ifB.o_win, 1);

        // Instance C: two levels then WON, restart with start+tick together
        doReset();
        applyStimulus(1, 0, 0, 0, 0, 0);
        tickN(20);
        checkOutput("C.l1Phase", ifC.o_phase, 1);
        checkOutput("C.l1Level", ifC.o_level, 1);
        checkOutput("C.lcEarly", ifC.o_level_chng, 0);
        stepIdle(1);
        checkOutput("C.lcPulse", ifC.o_level_chng, 1);
        stepIdle(1);
        checkOutput("C.lcDrop", ifC.o_level_chng, 0);
        tickN(18);
        checkOutput("C.post", ifC.o_phase, 4);
        tickN(2);
        checkOutput("C.won", ifC.o_phase, 6);
        checkOutput("C.win", ifC.o_win, 1);
        checkOutput("C.wonLevel", ifC.o_level, 1);
        checkOutput("C.wonCd", ifC.o_count_down, 0);
        checkOutput("C.psEarly", ifC.o_phase_start, 0);
        stepIdle(1);
        checkOutput("C.psPulse", ifC.o_phase_start, 1);
        stepIdle(1);
        checkOutput("C.psDrop", ifC.o_phase_start, 0);
        tickN(1);
        checkOutput("C.wonHold", ifC.o_phase, 6);
        applyStimulus(1, 1, 0, 0, 0, 0);
        checkOutput("C.restartPhase", ifC.o_phase, 1);
        checkOutput("C.restartCd", ifC.o_count_down, 3);
        checkOutput("C.restartLevel", ifC.o_level, 0);
        checkOutput("C.restartWin", ifC.o_win, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
